// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the IF/ID register control encoding.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          PC_INCR   = 4;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_ctl_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds, loads a fetched instruction, or inserts a bubble.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int             XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(riscv_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            reset,
  input  ifid_ctl_e       ctl,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            valid_out
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    case (ctl)
      IFID_LOAD: begin
        instr_d = instr_in;
        pc_d    = pc_in;
        valid_d = 1'b1;
      end
      IFID_BUBBLE: begin
        instr_d = NOP_INSTR;
        pc_d    = '0;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC priority mux and IF/ID capture.
// Optional misaligned-redirect check enabled by defining PC_MISALIGN_CHECK_EN.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(riscv_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_select,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            flush
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            redirect;
  ifid_ctl_e       ifid_ctl;

`ifdef PC_MISALIGN_CHECK_EN
  logic misaligned;
  logic misalign_err_q;

  assign misaligned = pc_select && (branch_target[1:0] != 2'b00);
  assign redirect   = pc_select && !misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err_q <= 1'b0;
    end else if (misaligned) begin
      misalign_err_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_err_q;
`else
  assign redirect = pc_select;
`endif

  // Reset discards any redirect, so the squash must not escape during reset.
  assign flush = redirect && !reset;

  always_comb begin
    pc_d     = pc_q;
    ifid_ctl = IFID_HOLD;
    if (redirect) begin
      pc_d     = branch_target;
      ifid_ctl = IFID_BUBBLE;
    end else if (stall) begin
      ifid_ctl = IFID_HOLD;
    end else if (!imem_ready) begin
      ifid_ctl = IFID_BUBBLE;
    end else begin
      pc_d     = pc_q + XLEN'(PC_INCR);
      ifid_ctl = IFID_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = pc_q;

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .ctl       (ifid_ctl),
    .instr_in  (imem_rdata),
    .pc_in     (pc_q),
    .instr_out (if_id_instr),
    .pc_out    (if_id_pc),
    .valid_out (if_id_valid)
  );

endmodule
